// File: rtl/avalon_mm_arbiter_pkg.sv
// Shared types for the Avalon-MM host merge: 32-bit word type and the
// host source ID carried through the pending-read FIFO.
package Types;

  typedef logic [31:0] uint32_t;

  typedef enum bit {SRC_INSTR, SRC_DATA} avalon_src_t;

  // The host that is not s; used to alternate on conflicts.
  function automatic avalon_src_t other_src(input avalon_src_t s);
    return (s == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
  endfunction

endpackage

// File: rtl/avalon_mm_arbiter_pending_src_fifo.sv
// Pending-read source FIFO: remembers which host issued each accepted read
// so that in-order responses can be steered back to it.
module pending_src_fifo
  import Types::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  avalon_src_t din,
  output avalon_src_t dout,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam int CNT_W = PTR_W + 1;

  avalon_src_t        mem [MAX_PENDING];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [CNT_W-1:0]   count;

  assign full  = (count == CNT_W'(MAX_PENDING));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  // Pointer and occupancy bookkeeping; reset discards every pending ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + PTR_W'(1);
      if (pop)
        rptr <= rptr + PTR_W'(1);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
    end
  end

  // Storage is data only; its contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= din;
  end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Round-robin merge of the CPU instruction and data Avalon-MM hosts onto one
// agent port, with pending-read tracking for response steering.
module avalon_mm_arbiter
  import Types::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_address,
  input  logic [3:0]  instr_byteenable,
  input  logic        instr_read,
  output logic        instr_waitrequest,
  output logic [31:0] instr_agent_to_host,
  output logic        instr_readdatavalid,
  input  logic [31:0] data_address,
  input  logic [3:0]  data_byteenable,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_host_to_agent,
  output logic        data_waitrequest,
  output logic [31:0] data_agent_to_host,
  output logic        data_readdatavalid,
  output logic [31:0] agent_address,
  output logic [3:0]  agent_byteenable,
  output logic        agent_read,
  output logic        agent_write,
  output logic [31:0] agent_host_to_agent,
  input  logic        agent_waitrequest,
  input  logic [31:0] agent_agent_to_host,
  input  logic        agent_readdatavalid,
  output logic        resp_error
);

  logic        instr_req;
  logic        data_req;
  logic        locked;
  avalon_src_t lock_src;
  avalon_src_t last_grant;
  avalon_src_t gnt_src;
  logic        gnt_active;
  logic        gnt_is_read;
  logic        read_block;
  logic        accept;
  logic        stall;
  logic        lock_held;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  avalon_src_t fifo_head;

  assign instr_req = instr_read;
  assign data_req  = data_read | data_write;

  // A lock only holds while its host keeps the stalled command up.
  assign lock_held = locked &&
                     ((lock_src == SRC_INSTR) ? instr_req : data_req);

  // Grant selection: lock first, then sole requester, then alternate.
  always_comb begin
    gnt_src    = SRC_INSTR;
    gnt_active = 1'b0;
    if (!rst) begin
      if (lock_held) begin
        gnt_src    = lock_src;
        gnt_active = 1'b1;
      end else if (instr_req && data_req) begin
        gnt_src    = other_src(last_grant);
        gnt_active = 1'b1;
      end else if (instr_req) begin
        gnt_src    = SRC_INSTR;
        gnt_active = 1'b1;
      end else if (data_req) begin
        gnt_src    = SRC_DATA;
        gnt_active = 1'b1;
      end
    end
  end

  assign gnt_is_read = gnt_active &&
                       ((gnt_src == SRC_INSTR) ? instr_read : data_read);
  assign read_block  = fifo_full & gnt_is_read;
  assign accept      = gnt_active & ~agent_waitrequest & ~read_block;
  assign stall       = gnt_active & agent_waitrequest;
  assign fifo_push   = accept & gnt_is_read;
  assign fifo_pop    = agent_readdatavalid & ~fifo_empty & ~rst;

  // Command mux from the granted host; all-zero when nothing is granted.
  always_comb begin
    agent_address       = '0;
    agent_byteenable    = '0;
    agent_read          = 1'b0;
    agent_write         = 1'b0;
    agent_host_to_agent = '0;
    if (gnt_active) begin
      if (gnt_src == SRC_INSTR) begin
        agent_address    = instr_address;
        agent_byteenable = instr_byteenable;
        agent_read       = instr_read & ~read_block;
      end else begin
        agent_address       = data_address;
        agent_byteenable    = data_byteenable;
        agent_read          = data_read & ~read_block;
        agent_write         = data_write;
        agent_host_to_agent = data_host_to_agent;
      end
    end
  end

  // Only the granted host can see its command go through.
  always_comb begin
    instr_waitrequest = 1'b1;
    data_waitrequest  = 1'b1;
    if (gnt_active) begin
      if (gnt_src == SRC_INSTR)
        instr_waitrequest = agent_waitrequest | read_block;
      else
        data_waitrequest  = agent_waitrequest | read_block;
    end
  end

  assign instr_agent_to_host = agent_agent_to_host;
  assign data_agent_to_host  = agent_agent_to_host;
  assign instr_readdatavalid = fifo_pop & (fifo_head == SRC_INSTR);
  assign data_readdatavalid  = fifo_pop & (fifo_head == SRC_DATA);

  // Arbitration state and sticky orphan-response flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked     <= 1'b0;
      lock_src   <= SRC_INSTR;
      last_grant <= SRC_INSTR;
      resp_error <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= gnt_src;
        locked     <= 1'b0;
      end else if (stall) begin
        locked   <= 1'b1;
        lock_src <= gnt_src;
      end else if (locked && !lock_held) begin
        locked <= 1'b0;
      end
      if (agent_readdatavalid && fifo_empty)
        resp_error <= 1'b1;
    end
  end

  pending_src_fifo #(
    .MAX_PENDING (MAX_PENDING)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (gnt_src),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Directed bench for avalon_mm_arbiter: inputs change just after the falling
// edge, outputs are sampled 1ns later, well away from the rising edge.
module tb_avalon_mm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_address;
  logic [3:0]  instr_byteenable;
  logic        instr_read;
  logic        instr_waitrequest;
  logic [31:0] instr_agent_to_host;
  logic        instr_readdatavalid;
  logic [31:0] data_address;
  logic [3:0]  data_byteenable;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_host_to_agent;
  logic        data_waitrequest;
  logic [31:0] data_agent_to_host;
  logic        data_readdatavalid;
  logic [31:0] agent_address;
  logic [3:0]  agent_byteenable;
  logic        agent_read;
  logic        agent_write;
  logic [31:0] agent_host_to_agent;
  logic        agent_waitrequest;
  logic [31:0] agent_agent_to_host;
  logic        agent_readdatavalid;
  logic        resp_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  avalon_mm_arbiter #(.MAX_PENDING(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .instr_address       (instr_address),
    .instr_byteenable    (instr_byteenable),
    .instr_read          (instr_read),
    .instr_waitrequest   (instr_waitrequest),
    .instr_agent_to_host (instr_agent_to_host),
    .instr_readdatavalid (instr_readdatavalid),
    .data_address        (data_address),
    .data_byteenable     (data_byteenable),
    .data_read           (data_read),
    .data_write          (data_write),
    .data_host_to_agent  (data_host_to_agent),
    .data_waitrequest    (data_waitrequest),
    .data_agent_to_host  (data_agent_to_host),
    .data_readdatavalid  (data_readdatavalid),
    .agent_address       (agent_address),
    .agent_byteenable    (agent_byteenable),
    .agent_read          (agent_read),
    .agent_write         (agent_write),
    .agent_host_to_agent (agent_host_to_agent),
    .agent_waitrequest   (agent_waitrequest),
    .agent_agent_to_host (agent_agent_to_host),
    .agent_readdatavalid (agent_readdatavalid),
    .resp_error          (resp_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    instr_address       = '0;
    instr_byteenable    = '0;
    instr_read          = 1'b0;
    data_address        = '0;
    data_byteenable     = '0;
    data_read           = 1'b0;
    data_write          = 1'b0;
    data_host_to_agent  = '0;
    agent_waitrequest   = 1'b0;
    agent_agent_to_host = '0;
    agent_readdatavalid = 1'b0;
  endtask

  // Advance one full clock: lands just after the next falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic respond(input logic [31:0] d);
    agent_readdatavalid = 1'b1;
    agent_agent_to_host = d;
  endtask

  initial begin
    logic [31:0] resp_tbl [4];
    resp_tbl[0] = 32'hAAAA_0001;
    resp_tbl[1] = 32'hBBBB_0002;
    resp_tbl[2] = 32'hCCCC_0003;
    resp_tbl[3] = 32'hDDDD_0004;

    // ---- Reset: commands held off, both hosts stalled
    idle();
    rst        = 1'b1;
    instr_read = 1'b1;
    data_write = 1'b1;
    cyc();
    #1;
    chk("rst_agent_read", 32'(agent_read), 32'd0);
    chk("rst_agent_write", 32'(agent_write), 32'd0);
    chk("rst_instr_wait", 32'(instr_waitrequest), 32'd1);
    chk("rst_data_wait", 32'(data_waitrequest), 32'd1);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    rst = 1'b0;
    idle();
    cyc();

    // ---- Single instruction read
    instr_read       = 1'b1;
    instr_address    = 32'h100;
    instr_byteenable = 4'hF;
    #1;
    chk("ir_agent_read", 32'(agent_read), 32'd1);
    chk("ir_agent_addr", agent_address, 32'h100);
    chk("ir_agent_be", 32'(agent_byteenable), 32'hF);
    chk("ir_instr_wait", 32'(instr_waitrequest), 32'd0);
    cyc();
    idle();
    cyc();
    respond(32'hDEADBEEF);
    #1;
    chk("ir_instr_rdv", 32'(instr_readdatavalid), 32'd1);
    chk("ir_instr_data", instr_agent_to_host, 32'hDEADBEEF);
    chk("ir_data_rdv", 32'(data_readdatavalid), 32'd0);
    chk("ir_data_bus", data_agent_to_host, 32'hDEADBEEF);
    cyc();
    idle();
    #1;
    chk("ir_no_err", 32'(resp_error), 32'd0);

    // ---- Conflict after reset: data first, then alternation
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idle();
      instr_read         = 1'b1;
      instr_address      = 32'h200;
      data_write         = 1'b1;
      data_address       = 32'h300;
      data_host_to_agent = 32'h11 + 32'(k);
      if (k % 2 == 0 && k > 0)
        respond(32'h5000 + 32'(k));
      #1;
      if (k % 2 == 0) begin
        chk("cf_addr_data", agent_address, 32'h300);
        chk("cf_write", 32'(agent_write), 32'd1);
        chk("cf_wdata", agent_host_to_agent, 32'h11 + 32'(k));
        chk("cf_instr_wait", 32'(instr_waitrequest), 32'd1);
        chk("cf_instr_rdv", 32'(instr_readdatavalid), (k > 0) ? 32'd1 : 32'd0);
      end else begin
        chk("cf_addr_instr", agent_address, 32'h200);
        chk("cf_read", 32'(agent_read), 32'd1);
        chk("cf_data_wait", 32'(data_waitrequest), 32'd1);
      end
      cyc();
    end
    idle();
    respond(32'h5008);
    #1;
    chk("cf_last_rdv", 32'(instr_readdatavalid), 32'd1);
    cyc();
    idle();
    #1;
    chk("cf_no_err", 32'(resp_error), 32'd0);

    // ---- Stall lock: instr stalled 3 cycles while data_write waits
    for (int s = 0; s < 3; s++) begin
      instr_read        = 1'b1;
      instr_address     = 32'h400;
      agent_waitrequest = 1'b1;
      if (s > 0) begin
        data_write   = 1'b1;
        data_address = 32'h500;
      end
      #1;
      chk("lk_addr", agent_address, 32'h400);
      chk("lk_read", 32'(agent_read), 32'd1);
      chk("lk_write", 32'(agent_write), 32'd0);
      chk("lk_instr_wait", 32'(instr_waitrequest), 32'd1);
      cyc();
    end
    agent_waitrequest = 1'b0;
    #1;
    chk("lk_accept_addr", agent_address, 32'h400);
    chk("lk_accept_wait", 32'(instr_waitrequest), 32'd0);
    chk("lk_data_wait", 32'(data_waitrequest), 32'd1);
    cyc();
    instr_read = 1'b0;
    #1;
    chk("lk_data_addr", agent_address, 32'h500);
    chk("lk_data_write", 32'(agent_write), 32'd1);
    chk("lk_data_go", 32'(data_waitrequest), 32'd0);
    cyc();
    idle();
    respond(32'h4444);
    #1;
    chk("lk_resp", 32'(instr_readdatavalid), 32'd1);
    cyc();
    idle();

    // ---- Pending limit: four reads fill the FIFO
    for (int r = 0; r < 4; r++) begin
      data_read    = 1'b1;
      data_address = 32'h600 + 32'(4 * r);
      #1;
      chk("pl_wait", 32'(data_waitrequest), 32'd0);
      chk("pl_read", 32'(agent_read), 32'd1);
      cyc();
    end
    data_address = 32'h610;
    #1;
    chk("pl_full_wait", 32'(data_waitrequest), 32'd1);
    chk("pl_full_read", 32'(agent_read), 32'd0);
    cyc();
    respond(32'h6000);
    #1;
    chk("pl_pop_wait", 32'(data_waitrequest), 32'd1);
    chk("pl_pop_read", 32'(agent_read), 32'd0);
    chk("pl_pop_rdv", 32'(data_readdatavalid), 32'd1);
    cyc();
    agent_readdatavalid = 1'b0;
    #1;
    chk("pl_5th_wait", 32'(data_waitrequest), 32'd0);
    chk("pl_5th_read", 32'(agent_read), 32'd1);
    chk("pl_5th_addr", agent_address, 32'h610);
    cyc();
    idle();
    for (int r = 0; r < 4; r++) begin
      respond(32'h6100 + 32'(r));
      #1;
      chk("pl_drain_rdv", 32'(data_readdatavalid), 32'd1);
      chk("pl_drain_irdv", 32'(instr_readdatavalid), 32'd0);
      cyc();
    end
    idle();

    // ---- Ordering: instr, data, data, instr
    instr_read = 1'b1; instr_address = 32'h700;
    cyc();
    idle(); data_read = 1'b1; data_address = 32'h704;
    cyc();
    data_address = 32'h708;
    cyc();
    idle(); instr_read = 1'b1; instr_address = 32'h70C;
    #1;
    chk("or_last_issue", 32'(agent_read), 32'd1);
    cyc();
    idle();
    for (int r = 0; r < 4; r++) begin
      respond(resp_tbl[r]);
      #1;
      chk("or_instr_rdv", 32'(instr_readdatavalid), (r == 0 || r == 3) ? 32'd1 : 32'd0);
      chk("or_data_rdv", 32'(data_readdatavalid), (r == 1 || r == 2) ? 32'd1 : 32'd0);
      chk("or_data", (r == 0 || r == 3) ? instr_agent_to_host : data_agent_to_host, resp_tbl[r]);
      cyc();
    end
    idle();
    #1;
    chk("or_no_err", 32'(resp_error), 32'd0);

    // ---- Orphan response and reset with reads pending
    respond(32'hE0E0);
    #1;
    chk("er_irdv", 32'(instr_readdatavalid), 32'd0);
    chk("er_drdv", 32'(data_readdatavalid), 32'd0);
    cyc();
    idle();
    #1;
    chk("er_flag", 32'(resp_error), 32'd1);
    instr_read = 1'b1; instr_address = 32'h800;
    cyc();
    instr_address = 32'h804;
    cyc();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("er_flag_clr", 32'(resp_error), 32'd0);
    respond(32'hE1E1);
    #1;
    chk("er_post_irdv", 32'(instr_readdatavalid), 32'd0);
    chk("er_post_drdv", 32'(data_readdatavalid), 32'd0);
    cyc();
    idle();
    #1;
    chk("er_flag_again", 32'(resp_error), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
